// File: rtl/sprite_print_engine_if.sv
// rtl/sprite_print_engine_if.sv - pixel, slot-write and result signals of the sprite print engine
// Signals:
//   pixel_en, active_area, pixel_x, pixel_y : pixel stream from the video timing generator
//   wr_en, wr_slot, wr_data                 : slot register write port
//   collision_clr                           : clears collision_sticky
//   memory_address, sprite_on, slot_id,
//   printing_screen, collision,
//   collision_sticky                        : pipelined lookup results
// Modports: master drives the pixel/write side, slave is the engine.
interface sprite_print_engine_if #(
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 9,
    parameter int SIZE_ADDRESS = 17,
    parameter int NUM_SPRITES  = 8
);
    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    logic                    pixel_en;
    logic                    active_area;
    logic [SIZE_X-1:0]       pixel_x;
    logic [SIZE_Y-1:0]       pixel_y;
    logic                    wr_en;
    logic [SLOT_W-1:0]       wr_slot;
    logic [31:0]             wr_data;
    logic                    collision_clr;
    logic [SIZE_ADDRESS-1:0] memory_address;
    logic                    sprite_on;
    logic [SLOT_W-1:0]       slot_id;
    logic                    printing_screen;
    logic                    collision;
    logic                    collision_sticky;

    modport master (
        output pixel_en, active_area, pixel_x, pixel_y,
        output wr_en, wr_slot, wr_data, collision_clr,
        input  memory_address, sprite_on, slot_id, printing_screen,
        input  collision, collision_sticky
    );

    modport slave (
        input  pixel_en, active_area, pixel_x, pixel_y,
        input  wr_en, wr_slot, wr_data, collision_clr,
        output memory_address, sprite_on, slot_id, printing_screen,
        output collision, collision_sticky
    );
endinterface

// File: rtl/sprite_print_engine.sv
// rtl/sprite_print_engine.sv - two-stage sprite lookup producing sprite ROM addresses per pixel
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : sprite_print_engine_if.slave (pixel stream, slot writes, pipelined results)
// Slot word: [31] enable, [30] hflip, [29:20] x, [19:11] y, [7:0] offset.
module sprite_print_engine #(
    parameter int SIZE_X       = 10,
    parameter int SIZE_Y       = 9,
    parameter int SIZE_ADDRESS = 17,
    parameter int NUM_SPRITES  = 8,
    parameter int SPRITE_DIM   = 20,
    parameter int OFFSET_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    sprite_print_engine_if.slave bus
);
    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int DIM_W  = (SPRITE_DIM > 1) ? $clog2(SPRITE_DIM) : 1;

    logic [31:0] r_slot [NUM_SPRITES];

    // Hit test; the end coordinate carries one extra bit so that a sprite
    // placed near the right/bottom edge does not wrap to column/row 0.
    function automatic logic f_hit(input logic [31:0] word,
                                   input logic [SIZE_X-1:0] px,
                                   input logic [SIZE_Y-1:0] py);
        logic [SIZE_X-1:0] x;
        logic [SIZE_Y-1:0] y;
        logic [SIZE_X:0]   x_end;
        logic [SIZE_Y:0]   y_end;
        x     = word[20 +: SIZE_X];
        y     = word[11 +: SIZE_Y];
        x_end = {1'b0, x} + (SIZE_X+1)'(SPRITE_DIM - 1);
        y_end = {1'b0, y} + (SIZE_Y+1)'(SPRITE_DIM - 1);
        return word[31] && (px >= x) && ({1'b0, px} <= x_end)
                        && (py >= y) && ({1'b0, py} <= y_end);
    endfunction

    // Slot registers; out-of-range slot indices are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_SPRITES; s++) r_slot[s] <= '0;
        end else if (bus.wr_en && (32'(bus.wr_slot) < 32'(NUM_SPRITES))) begin
            r_slot[bus.wr_slot] <= bus.wr_data;
        end
    end

    logic              w_any_hit;
    logic [SLOT_W-1:0] w_win;
    logic [31:0]       w_win_word;
    logic [5:0]        w_hit_cnt;
    logic [SIZE_X-1:0] w_dx;
    logic [SIZE_Y-1:0] w_dy;
    logic [DIM_W-1:0]  w_col;
    logic [DIM_W-1:0]  w_line;

    // Scan from the top slot down so the last hit recorded is the lowest index.
    always_comb begin
        w_any_hit  = 1'b0;
        w_win      = '0;
        w_win_word = '0;
        w_hit_cnt  = '0;
        for (int s = NUM_SPRITES - 1; s >= 0; s--) begin
            if (bus.active_area && f_hit(r_slot[s], bus.pixel_x, bus.pixel_y)) begin
                w_any_hit  = 1'b1;
                w_win      = SLOT_W'(s);
                w_win_word = r_slot[s];
                w_hit_cnt  = w_hit_cnt + 6'd1;
            end
        end
        w_dx   = bus.pixel_x - w_win_word[20 +: SIZE_X];
        w_dy   = bus.pixel_y - w_win_word[11 +: SIZE_Y];
        w_col  = DIM_W'(w_dx);
        w_line = DIM_W'(w_dy);
        if (w_win_word[30]) w_col = DIM_W'(SPRITE_DIM - 1) - w_col;
    end

    logic                   r_s1_hit;
    logic [SLOT_W-1:0]      r_s1_slot;
    logic                   r_s1_coll;
    logic [DIM_W-1:0]       r_s1_col;
    logic [DIM_W-1:0]       r_s1_line;
    logic [OFFSET_BITS-1:0] r_s1_off;
    logic                   r_s1_active;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_hit    <= 1'b0;
            r_s1_slot   <= '0;
            r_s1_coll   <= 1'b0;
            r_s1_col    <= '0;
            r_s1_line   <= '0;
            r_s1_off    <= '0;
            r_s1_active <= 1'b0;
        end else if (bus.pixel_en) begin
            r_s1_hit    <= w_any_hit;
            r_s1_slot   <= w_win;
            r_s1_coll   <= (w_hit_cnt >= 6'd2);
            r_s1_col    <= w_col;
            r_s1_line   <= w_line;
            r_s1_off    <= w_win_word[0 +: OFFSET_BITS];
            r_s1_active <= bus.active_area;
        end
    end

    logic [31:0] w_addr;
    assign w_addr = 32'(r_s1_off) * 32'(SPRITE_DIM * SPRITE_DIM)
                  + 32'(r_s1_line) * 32'(SPRITE_DIM)
                  + 32'(r_s1_col);

    logic [SIZE_ADDRESS-1:0] r_addr;
    logic                    r_on;
    logic [SLOT_W-1:0]       r_slot_id;
    logic                    r_printing;
    logic                    r_coll;
    logic                    r_sticky;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr     <= '0;
            r_on       <= 1'b0;
            r_slot_id  <= '0;
            r_printing <= 1'b0;
            r_coll     <= 1'b0;
        end else if (bus.pixel_en) begin
            r_addr     <= r_s1_hit ? SIZE_ADDRESS'(w_addr) : '0;
            r_on       <= r_s1_hit;
            r_slot_id  <= r_s1_hit ? r_s1_slot : '0;
            r_printing <= r_s1_active;
            r_coll     <= r_s1_coll;
        end
    end

    // A collision entering stage 2 beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          r_sticky <= 1'b0;
        else if (bus.pixel_en && r_s1_coll)  r_sticky <= 1'b1;
        else if (bus.collision_clr)          r_sticky <= 1'b0;
    end

    assign bus.memory_address   = r_addr;
    assign bus.sprite_on        = r_on;
    assign bus.slot_id          = r_slot_id;
    assign bus.printing_screen  = r_printing;
    assign bus.collision        = r_coll;
    assign bus.collision_sticky = r_sticky;
endmodule
